// File: rtl/usb_tx_pkt_arb.sv
// usb_tx_pkt_arb
// Shares the USB token/handshake encoder between the handshake responder
// (req0) and the host token engine (req1). Each grant is launched as one
// enc_valid pulse. The arbiter then waits for the encoder to drop and
// re-raise its ready, and holds an inter-packet gap before the next grant.
//
// Handshake semantics, used on every request port:
//   - reqN_valid is raised with pid/addr/endp stable and held until
//     reqN_ready.
//   - A transfer happens in the cycle where reqN_valid && reqN_ready.
//   - reqN_ready is a combinational one-cycle pulse, only ever given in IDLE.
//   - A requester may drop valid before ready; it is then simply not
//     granted.
//   - Toward the encoder, enc_valid is asserted only while enc_ready is
//     high, so every pulse is a completed transfer.
module usb_tx_pkt_arb #(
  parameter int unsigned IPG_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,

  input  logic       req0_valid,
  input  logic [3:0] req0_pid,
  input  logic [6:0] req0_addr,
  input  logic [3:0] req0_endp,
  output logic       req0_ready,
  output logic       req0_done,

  input  logic       req1_valid,
  input  logic [3:0] req1_pid,
  input  logic [6:0] req1_addr,
  input  logic [3:0] req1_endp,
  output logic       req1_ready,
  output logic       req1_done,

  output logic       enc_valid,
  output logic [3:0] enc_pid,
  output logic [6:0] enc_addr,
  output logic [3:0] enc_endp,
  input  logic       enc_ready,

  output logic       busy,
  output logic       grant_id,
  output logic       pid_err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_e;

  // The gap counter is loaded with IPG_CYCLES-1 so that GAP lasts exactly
  // IPG_CYCLES cycles. With IPG_CYCLES of 0, GAP is bypassed and this value
  // is never used.
  localparam logic [7:0] GAP_LOAD = (IPG_CYCLES == 0) ? 8'd0 : 8'(IPG_CYCLES - 1);

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       grant_id_q, grant_id_d;
  logic       armed_q, armed_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic [3:0] pid_q, pid_d;
  logic [6:0] addr_q, addr_d;
  logic [3:0] endp_q, endp_d;
  logic       pid_err_q, pid_err_d;

  logic       any_valid;
  logic       winner;
  logic       accept;
  logic [3:0] sel_pid;
  logic [6:0] sel_addr;
  logic [3:0] sel_endp;
  logic       sel_pid_legal;
  logic       done_evt;

  // Winner selection: a lone requester wins; on a tie, the requester that
  // was not granted last time wins.
  always_comb begin
    any_valid     = req0_valid | req1_valid;
    winner        = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    accept        = (state_q == S_IDLE) & any_valid;
    sel_pid       = winner ? req1_pid  : req0_pid;
    sel_addr      = winner ? req1_addr : req0_addr;
    sel_endp      = winner ? req1_endp : req0_endp;
    sel_pid_legal = (sel_pid[1:0] == 2'b01) | (sel_pid[1:0] == 2'b10);
  end

  // Handshake and status outputs, all derived from the current state.
  always_comb begin
    req0_ready = accept & ~winner;
    req1_ready = accept & winner;
    enc_valid  = (state_q == S_LAUNCH) & enc_ready;
    // The encoder's ready only counts as completion after it has been seen
    // low, so the ready still high from the launch cycle is not mistaken
    // for the end of the packet.
    done_evt   = (state_q == S_WAIT_DONE) & armed_q & enc_ready;
    req0_done  = done_evt & ~grant_id_q;
    req1_done  = done_evt & grant_id_q;
    enc_pid    = pid_q;
    enc_addr   = addr_q;
    enc_endp   = endp_q;
    busy       = (state_q != S_IDLE);
    grant_id   = grant_id_q;
    pid_err    = pid_err_q;
    dbg_state  = state_q;
  end

  // Next-state logic: sequencing through accept, launch, completion and gap.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    armed_d      = armed_q;
    gap_cnt_d    = gap_cnt_q;
    pid_d        = pid_q;
    addr_d       = addr_q;
    endp_d       = endp_q;
    pid_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          pid_d        = sel_pid;
          addr_d       = sel_addr;
          endp_d       = sel_endp;
          grant_id_d   = winner;
          last_grant_d = winner;
          if (sel_pid_legal) begin
            state_d = S_LAUNCH;
          end else begin
            // An illegal PID is dropped. The round-robin pointer still
            // moves, so a requester that keeps sending bad PIDs cannot
            // starve the other one.
            pid_err_d = 1'b1;
          end
        end
      end

      S_LAUNCH: begin
        if (enc_ready) begin
          state_d = S_WAIT_DONE;
          armed_d = 1'b0;
        end
      end

      S_WAIT_DONE: begin
        if (!enc_ready) begin
          armed_d = 1'b1;
        end
        if (done_evt) begin
          if (IPG_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and holding registers. Reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      armed_q      <= 1'b0;
      gap_cnt_q    <= 8'd0;
      pid_q        <= 4'd0;
      addr_q       <= 7'd0;
      endp_q       <= 4'd0;
      pid_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      armed_q      <= armed_d;
      gap_cnt_q    <= gap_cnt_d;
      pid_q        <= pid_d;
      addr_q       <= addr_d;
      endp_q       <= endp_d;
      pid_err_q    <= pid_err_d;
    end
  end

endmodule
